// File: rtl/addx_accel_fu.sv
// ADDX accelerator functional unit: one operation at a time, summed CHUNK_W bits per
// cycle through a registered carry chain, result returned on a no-backpressure writeback port.
module addx_accel_fu #(
    parameter int XLEN          = 64,
    parameter int CHUNK_W       = 16,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               fu_op_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     wt_valid_o,
    output logic                     ex_valid_o
);

    localparam int N     = XLEN / CHUNK_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_ADDUW = 2'b10;

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_carry;
    logic [XLEN-1:0]          r_a;
    logic [XLEN-1:0]          r_b;
    logic [XLEN-1:0]          r_sum;
    logic [TRANS_ID_BITS-1:0] r_tid;
    logic [XLEN-1:0]          r_result;
    logic [TRANS_ID_BITS-1:0] r_trans_id;
    logic                     r_ex;

    logic                     w_accept;
    logic                     w_last;
    logic [XLEN-1:0]          w_a_pre;
    logic [XLEN-1:0]          w_b_pre;
    logic                     w_cin_pre;
    logic [CHUNK_W:0]         w_chunk_sum;
    logic [XLEN-1:0]          w_sum_next;

    assign ready_o    = (r_state == S_IDLE);
    assign w_accept   = valid_i & ready_o & ~flush_i;
    // A flush arriving in DONE must kill the pulse in the same cycle, hence flush_i here.
    assign wt_valid_o = (r_state == S_DONE) & ~flush_i;
    assign result_o   = r_result;
    assign trans_id_o = r_trans_id;
    assign ex_valid_o = r_ex;

    always_comb begin
        w_a_pre   = operand_a_i;
        w_b_pre   = operand_b_i;
        w_cin_pre = 1'b0;
        case (fu_op_i)
            OP_SUB: begin
                w_b_pre   = ~operand_b_i;
                w_cin_pre = 1'b1;
            end
            OP_ADDUW: begin
                w_a_pre = {{(XLEN-32){1'b0}}, operand_a_i[31:0]};
            end
            default: begin
                w_a_pre   = operand_a_i;
                w_b_pre   = operand_b_i;
                w_cin_pre = 1'b0;
            end
        endcase
    end

    // Operands shift down one chunk per cycle; the sum fills in from the top.
    assign w_chunk_sum = {1'b0, r_a[CHUNK_W-1:0]} + {1'b0, r_b[CHUNK_W-1:0]}
                       + {{CHUNK_W{1'b0}}, r_carry};
    assign w_sum_next  = {w_chunk_sum[CHUNK_W-1:0], r_sum[XLEN-1:CHUNK_W]};
    assign w_last      = (r_cnt == CNT_W'(N - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_tid      <= '0;
            r_result   <= '0;
            r_trans_id <= '0;
            r_ex       <= 1'b0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (fu_op_i == 2'b11) begin
                            r_state    <= S_DONE;
                            r_result   <= '0;
                            r_trans_id <= trans_id_i;
                            r_ex       <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_a     <= w_a_pre;
                            r_b     <= w_b_pre;
                            r_carry <= w_cin_pre;
                            r_cnt   <= '0;
                            r_sum   <= '0;
                            r_tid   <= trans_id_i;
                        end
                    end
                end
                S_CALC: begin
                    r_a   <= r_a >> CHUNK_W;
                    r_b   <= r_b >> CHUNK_W;
                    r_sum <= w_sum_next;
                    if (w_last) begin
                        // Final carry-out is dropped: result wraps modulo 2^XLEN.
                        r_state    <= S_DONE;
                        r_cnt      <= '0;
                        r_carry    <= 1'b0;
                        r_result   <= w_sum_next;
                        r_trans_id <= r_tid;
                        r_ex       <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_carry <= w_chunk_sum[CHUNK_W];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
